// File: rtl/flash_pkg.sv
// Shared types and timing defaults for the flash generator/capture pair.
// Tolerance helper compares unsigned values in both orderings to avoid wrap.
package flash_pkg;

  localparam int CNT_W_DEF      = 17;
  localparam int EXP_ON_DEF     = 513;
  localparam int EXP_PERIOD_DEF = 1025;
  localparam int TOL_DEF        = 4;
  localparam int TIMEOUT_DEF    = 4096;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  function automatic logic within_tol(
    input logic [31:0] v,
    input logic [31:0] e,
    input logic [31:0] t
  );
    if (v >= e) return (v - e) <= t;
    else        return (e - v) <= t;
  endfunction

endpackage

// File: rtl/flash_edge_sync.sv
// Two-flop synchronizer for the flash line plus a history flop
// giving single-cycle rise/fall strobes.
module flash_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic flash_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= flash_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/flash_capture.sv
// Measures high-time and period of a flash line, checks them against
// expected values and flags a line stuck high or low.
module flash_capture
  import flash_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_ON     = EXP_ON_DEF,
  parameter int EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flash_in,
  output logic [CNT_W-1:0] on_width,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             match,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             level
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

  logic lvl, rise, fall, edge_w, tmo;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_q, meas_d;
  logic             match_q, match_d;
  logic             shi_q, shi_d;
  logic             slo_q, slo_d;

  flash_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .flash_in (flash_in),
    .level    (lvl),
    .rise     (rise),
    .fall     (fall)
  );

  assign edge_w = rise | fall;
  assign tmo    = !edge_w && (cnt_q == TMO);

  always_comb begin
    cnt_d     = cnt_q;
    per_cnt_d = per_cnt_q;
    hi_len_d  = hi_len_q;
    if (edge_w)              cnt_d = ONE;
    else if (cnt_q != CMAX)  cnt_d = cnt_q + ONE;
    if (rise)                    per_cnt_d = ONE;
    else if (per_cnt_q != CMAX)  per_cnt_d = per_cnt_q + ONE;
    if (fall) hi_len_d = cnt_q;
  end

  always_comb begin
    state_d  = state_q;
    on_d     = on_q;
    period_d = period_q;
    meas_d   = 1'b0;
    match_d  = match_q;
    shi_d    = shi_q;
    slo_d    = slo_q;
    if (edge_w) begin
      shi_d = 1'b0;
      slo_d = 1'b0;
    end
    // an edge in the same cycle always overrides the timeout
    if (tmo) begin
      state_d = IDLE;
      shi_d   = lvl;
      slo_d   = !lvl;
    end else begin
      unique case (state_q)
        IDLE: if (rise) state_d = HIGH;
        HIGH: if (fall) state_d = LOW;
        LOW: begin
          if (rise) begin
            on_d     = hi_len_q;
            period_d = per_cnt_q;
            meas_d   = 1'b1;
            match_d  = within_tol(32'(hi_len_q), 32'(EXP_ON), 32'(TOL))
                    && within_tol(32'(per_cnt_q), 32'(EXP_PERIOD), 32'(TOL));
            state_d  = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_cnt_q <= '0;
      hi_len_q  <= '0;
      on_q      <= '0;
      period_q  <= '0;
      meas_q    <= 1'b0;
      match_q   <= 1'b0;
      shi_q     <= 1'b0;
      slo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_cnt_q <= per_cnt_d;
      hi_len_q  <= hi_len_d;
      on_q      <= on_d;
      period_q  <= period_d;
      meas_q    <= meas_d;
      match_q   <= match_d;
      shi_q     <= shi_d;
      slo_q     <= slo_d;
    end
  end

  assign on_width   = on_q;
  assign period     = period_q;
  assign meas_valid = meas_q;
  assign match      = match_q;
  assign stuck_hi   = shi_q;
  assign stuck_lo   = slo_q;
  assign level      = lvl;

endmodule

// File: tb/tb_flash_capture.sv
// Randomized pulse-train bench for flash_capture with a per-pulse
// reference model feeding a scoreboard queue.
module tb_flash_capture;

  localparam int TO   = 4096;
  localparam int EON  = 513;
  localparam int EPER = 1025;
  localparam int TOLV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flash_in = 1'b0;
  logic [16:0] on_width, period;
  logic        meas_valid, match, stuck_hi, stuck_lo, level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int on;
    int per;
    int m;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   prev_h = 0;
  int   prev_l = 0;
  bit   prev_ok = 1'b0;

  flash_capture #(
    .CNT_W(17), .EXP_ON(EON), .EXP_PERIOD(EPER), .TOL(TOLV), .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flash_in   (flash_in),
    .on_width   (on_width),
    .period     (period),
    .meas_valid (meas_valid),
    .match      (match),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo),
    .level      (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int in_tol(input int v, input int e);
    int d;
    d = (v > e) ? v - e : e - v;
    return (d <= TOLV) ? 1 : 0;
  endfunction

  // one pulse: h samples high then l samples low
  task automatic pulse(input int h, input int l);
    exp_t e;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      if (i == 0 && prev_ok && prev_h <= TO && prev_l <= TO) begin
        e.on  = prev_h;
        e.per = prev_h + prev_l;
        e.m   = in_tol(prev_h, EON) & in_tol(prev_h + prev_l, EPER);
        e.at  = cyc + 3;
        q.push_back(e);
      end
      flash_in = 1'b1;
      if (prev_l > TO && i == 2) chk("stuck_lo_held", int'(stuck_lo), 1);
      if (prev_l > TO && i == 3) chk("stuck_lo_clear", int'(stuck_lo), 0);
      if (h > TO && i == TO + 2) chk("stuck_hi_early", int'(stuck_hi), 0);
      if (h > TO && i == TO + 3) begin
        chk("stuck_hi_set", int'(stuck_hi), 1);
        chk("stuck_excl", int'(stuck_lo), 0);
      end
    end
    for (int j = 0; j < l; j++) begin
      @(negedge clk);
      flash_in = 1'b0;
      if (h > TO && j == 2) chk("stuck_hi_held", int'(stuck_hi), 1);
      if (h > TO && j == 3) chk("stuck_hi_clear", int'(stuck_hi), 0);
      if (l > TO && j == TO + 2) chk("stuck_lo_early", int'(stuck_lo), 0);
      if (l > TO && j == TO + 3) chk("stuck_lo_set", int'(stuck_lo), 1);
    end
    prev_ok = 1'b1;
    prev_h  = h;
    prev_l  = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      flash_in = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_on_width"}, int'(on_width), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_stuck_hi"}, int'(stuck_hi), 0);
    chk({tag, "_stuck_lo"}, int'(stuck_lo), 0);
    chk({tag, "_level"}, int'(level), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas_valid actual=1 required=0 cyc=%0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("on_width", int'(on_width), mon_e.on);
        chk("period", int'(period), mon_e.per);
        chk("match", int'(match), mon_e.m);
        chk("meas_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    int h, l;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(10);

    repeat (4) pulse(513, 512);
    pulse(520, 505);
    pulse(520, 505);
    pulse(509, 516);
    pulse(508, 517);
    pulse(517, 508);
    pulse(518, 507);
    pulse(513, 512);

    pulse(5000, 600);
    pulse(513, 512);
    pulse(513, 512);
    pulse(513, 4200);
    pulse(513, 512);
    pulse(513, 512);

    repeat (5) pulse(1, 3);

    pulse(513, 512);
    pulse(513, 300);
    #3 rst_n = 1'b0;
    #1 chk_zero("midreset");
    chk("queue_at_reset", q.size(), 0);
    repeat (4) @(negedge clk);
    rst_n   = 1'b1;
    prev_ok = 1'b0;
    prev_h  = 0;
    prev_l  = 0;
    idle(100);
    pulse(513, 512);
    pulse(513, 512);
    pulse(513, 512);

    for (int k = 0; k < 20; k++) begin
      h = 513 + int'($urandom_range(0, 12)) - 6;
      l = 512 + int'($urandom_range(0, 12)) - 6;
      pulse(h, l);
    end
    for (int k = 0; k < 60; k++) begin
      h = 1 + int'($urandom_range(0, 39));
      l = 1 + int'($urandom_range(0, 39));
      pulse(h, l);
    end
    pulse(513, 512);
    idle(20);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
